// File: rtl/onehot_hit_counter.sv
// Samples the 2-to-4 decoder lines on a strobe and checks that exactly one is set.
// Keeps per-line hit counts and an illegal-pattern count, and the code of the last legal line.
// Optional build macro HIT_WRAP_EN: hit counters wrap with sticky per-line ovf flags (default: saturate, ovf=0).
module onehot_hit_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample,
  input  logic [3:0]    y,
  input  logic          clr,
  input  logic [1:0]    rd_sel,
  output logic [CW-1:0] cnt_rd,
  output logic [CW-1:0] bad_cnt,
  output logic [1:0]    last_code,
  output logic          code_vld,
  output logic          err,
  output logic [3:0]    ovf
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] hit [4];
  logic [2:0]    ones;
  logic          legal;
  logic [1:0]    code;

  // Legality is a true popcount, so multi-hot can never reach a hit counter.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ones = ones + 3'(y[i]);
    end
  end

  assign legal = (ones == 3'd1);
  assign code  = {y[3] | y[2], y[3] | y[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 4; k++) hit[k] <= '0;
      bad_cnt   <= '0;
      last_code <= '0;
      code_vld  <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      for (int unsigned k = 0; k < 4; k++) hit[k] <= '0;
      bad_cnt   <= '0;
      last_code <= '0;
      code_vld  <= 1'b0;
      err       <= 1'b0;
    end else if (sample) begin
      if (legal) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (y[k]) begin
`ifdef HIT_WRAP_EN
            hit[k] <= hit[k] + 1'b1;
`else
            if (hit[k] != CNT_MAX) hit[k] <= hit[k] + 1'b1;
`endif
          end
        end
        last_code <= code;
        code_vld  <= 1'b1;
      end else begin
        if (bad_cnt != CNT_MAX) bad_cnt <= bad_cnt + 1'b1;
        err <= 1'b1;
      end
    end
  end

`ifdef HIT_WRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= '0;
    end else if (clr) begin
      ovf <= '0;
    end else if (sample && legal) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (y[k] && hit[k] == CNT_MAX) ovf[k] <= 1'b1;
      end
    end
  end
`else
  assign ovf = '0;
`endif

  assign cnt_rd = hit[rd_sel];

endmodule

// File: tb/tb_onehot_hit_counter.sv
// Directed bench for onehot_hit_counter (CW=4); expectations follow HIT_WRAP_EN when defined.
module tb_onehot_hit_counter;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample = 1'b0;
  logic [3:0]    y = '0;
  logic          clr = 1'b0;
  logic [1:0]    rd_sel = '0;
  logic [CW-1:0] cnt_rd;
  logic [CW-1:0] bad_cnt;
  logic [1:0]    last_code;
  logic          code_vld;
  logic          err;
  logic [3:0]    ovf;

  int tests_run = 0;
  int tests_failed = 0;

  onehot_hit_counter #(.CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sample   (sample),
    .y        (y),
    .clr      (clr),
    .rd_sel   (rd_sel),
    .cnt_rd   (cnt_rd),
    .bad_cnt  (bad_cnt),
    .last_code(last_code),
    .code_vld (code_vld),
    .err      (err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] v);
    sample = 1'b1;
    y      = v;
    tick();
    sample = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_hits(input string tag, input int h3, input int h2, input int h1, input int h0);
    int exp [4];
    exp = '{h0, h1, h2, h3};
    for (int k = 0; k < 4; k++) begin
      rd_sel = 2'(k);
      #1;
      check($sformatf("%s_hit%0d", tag, k), int'(cnt_rd), exp[k]);
    end
  endtask

  task automatic chk_status(input string tag, input int bad, input int lc, input int vld, input int e);
    check({tag, "_bad_cnt"},   int'(bad_cnt),   bad);
    check({tag, "_last_code"}, int'(last_code), lc);
    check({tag, "_code_vld"},  int'(code_vld),  vld);
    check({tag, "_err"},       int'(err),       e);
  endtask

  initial begin
    // Reset state, held while rst is high across clock edges
    #2;
    tick();
    chk_hits("rst", 0, 0, 0, 0);
    chk_status("rst", 0, 0, 0, 0);
    check("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Async reset mid-run discards earlier activity
    strobe(4'b0001);
    strobe(4'b0000);
    #2;
    rst = 1'b1;
    #1;
    chk_hits("async", 0, 0, 0, 0);
    chk_status("async", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    strobe(4'b0100);
    chk_hits("after_rst", 0, 1, 0, 0);
    chk_status("after_rst", 0, 2, 1, 0);

    // Back-to-back legal strobes
    do_clr();
    strobe(4'b0001);
    strobe(4'b0010);
    strobe(4'b1000);
    strobe(4'b1000);
    chk_hits("b2b", 2, 0, 1, 1);
    chk_status("b2b", 0, 3, 1, 0);

    // Illegal patterns: zero-hot and multi-hot
    strobe(4'b0000);
    strobe(4'b0110);
    chk_hits("illegal", 2, 0, 1, 1);
    chk_status("illegal", 2, 3, 1, 1);

    // Ignored inputs while sample is low
    do_clr();
    y = 4'b1111;
    repeat (5) tick();
    y = 4'bxxxx;
    repeat (5) tick();
    y = '0;
    chk_hits("idle", 0, 0, 0, 0);
    chk_status("idle", 0, 0, 0, 0);

    // Hit counter limit on line 0
    repeat (20) strobe(4'b0001);
`ifdef HIT_WRAP_EN
    chk_hits("limit", 0, 0, 0, 4);
    check("limit_ovf", int'(ovf), 1);
`else
    chk_hits("limit", 0, 0, 0, 15);
    check("limit_ovf", int'(ovf), 0);
`endif
    // A hit on a saturated/wrapped line still updates last_code
    strobe(4'b0010);
    check("lc_line1", int'(last_code), 1);
    strobe(4'b0001);
    check("lc_line0", int'(last_code), 0);

    // bad_cnt saturates in every build
    repeat (17) strobe(4'b1100);
    chk_status("bad_sat", 15, 0, 1, 1);

    // clr wins over a simultaneous sample
    clr    = 1'b1;
    sample = 1'b1;
    y      = 4'b0010;
    tick();
    clr    = 1'b0;
    sample = 1'b0;
    chk_hits("clr_pri", 0, 0, 0, 0);
    chk_status("clr_pri", 0, 0, 0, 0);
    check("clr_pri_ovf", int'(ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
